// File: rtl/fpu_ss_mem_tracker.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// fpu_ss_mem_tracker
//
// In-order tracker for outstanding FPU load/store operations. Each issued
// memory op occupies one slot of a circular buffer holding
// {id, rd, we, done, killed, err}. Memory results complete the oldest
// still-pending op, commit kills flag ops by id, and completed ops leave
// from the head strictly in issue order. Killed ops are dropped silently
// when they reach the head.
//
// Parameters:
//   ID_WIDTH - width of the offload instruction id
//   DEPTH    - number of outstanding ops (power of two, >= 2)
//   RD_WIDTH - width of the destination register address
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   push_*                issue of a load/store (valid/ready handshake);
//                         push_we_i=1 marks an FP-register load
//   commit_*              commit interface; commit_kill_i flags ops by id
//   result_*              memory result, no backpressure
//   out_*                 completed op leaving the head (valid/ready)
//   empty_o, full_o       occupancy flags
//   count_o               number of occupied slots
//   id_mismatch_o         one-cycle registered pulse when a result's id does
//                         not match the op it completed
//
// Build options:
//   FPU_SS_MEM_ID_CHECK_EN - when defined, results are compared against the
//                            id of the op they complete and id_mismatch_o
//                            reports differences; when undefined the output
//                            is tied low and no comparator is built.
// ---------------------------------------------------------------------------
module fpu_ss_mem_tracker #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 4,
    parameter int RD_WIDTH = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [ID_WIDTH-1:0]          push_id_i,
    input  logic [RD_WIDTH-1:0]          push_rd_i,
    input  logic                         push_we_i,

    input  logic                         commit_valid_i,
    input  logic [ID_WIDTH-1:0]          commit_id_i,
    input  logic                         commit_kill_i,

    input  logic                         result_valid_i,
    input  logic [ID_WIDTH-1:0]          result_id_i,
    input  logic                         result_err_i,

    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ID_WIDTH-1:0]          out_id_o,
    output logic [RD_WIDTH-1:0]          out_rd_o,
    output logic                         out_we_o,
    output logic                         out_err_o,

    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         id_mismatch_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // -----------------------------------------------------------------------
    // Buffer bookkeeping
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0]    head_reg;
    logic [PTR_W-1:0]    tail_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    count_next;

    // Per-slot state, gathered from the generate blocks below
    logic [DEPTH-1:0]    entry_valid;
    logic [DEPTH-1:0]    entry_done;
    logic [DEPTH-1:0]    entry_killed;
    logic [DEPTH-1:0]    entry_err;
    logic [DEPTH-1:0]    entry_we;
    logic [ID_WIDTH-1:0] entry_id [DEPTH];
    logic [RD_WIDTH-1:0] entry_rd [DEPTH];

    // Slots hit by this cycle's kill (not yet registered)
    logic [DEPTH-1:0]    kill_hit;

    logic                kill_en;
    logic                push_fire;
    logic                head_drop;
    logic                pop_fire;
    logic                deq;

    logic                cand_found;
    logic [PTR_W-1:0]    cand_sel;
    logic [PTR_W-1:0]    scan_idx;
    logic                res_hit;

    assign full_o       = (count_reg == CNT_W'(DEPTH));
    assign empty_o      = (count_reg == '0);
    assign count_o      = count_reg;
    assign push_ready_o = !full_o;

    // A full buffer refuses pushes even if the head leaves this cycle.
    assign push_fire = push_valid_i && !full_o;
    assign kill_en   = commit_valid_i && commit_kill_i;

    // -----------------------------------------------------------------------
    // Head: a completed live op is offered; a killed op is discarded without
    // being offered, done or not. Both act on registered state only, so a
    // result never reaches the output in the cycle it arrives.
    // -----------------------------------------------------------------------
    assign out_valid_o = entry_valid[head_reg] && entry_done[head_reg] && !entry_killed[head_reg];
    assign head_drop   = entry_valid[head_reg] && entry_killed[head_reg];
    assign pop_fire    = out_valid_o && out_ready_i;
    assign deq         = pop_fire || head_drop;

    assign out_id_o  = entry_id[head_reg];
    assign out_rd_o  = entry_rd[head_reg];
    assign out_we_o  = entry_we[head_reg];
    assign out_err_o = entry_err[head_reg];

    // -----------------------------------------------------------------------
    // Result target: oldest valid slot that is still pending and is not
    // killed, counting this cycle's kill. A slot being pushed this cycle is
    // still invalid here, so it cannot be selected.
    // -----------------------------------------------------------------------
    always_comb begin
        cand_found = 1'b0;
        cand_sel   = head_reg;
        scan_idx   = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (!cand_found && entry_valid[scan_idx] && !entry_done[scan_idx] &&
                !(entry_killed[scan_idx] || kill_hit[scan_idx])) begin
                cand_found = 1'b1;
                cand_sel   = scan_idx;
            end
        end
    end

    assign res_hit = result_valid_i && cand_found;

    // -----------------------------------------------------------------------
    // Pointers and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        count_next = count_reg + CNT_W'(push_fire) - CNT_W'(deq);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_fire) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (deq) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Slot storage. Every slot can be killed or completed in parallel, so
    // each is its own small register set rather than a RAM.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic                valid_reg;
        logic                done_reg;
        logic                killed_reg;
        logic                err_reg;
        logic                we_reg;
        logic [ID_WIDTH-1:0] id_reg;
        logic [RD_WIDTH-1:0] rd_reg;

        logic push_here;
        logic deq_here;
        logic res_here;

        assign push_here    = push_fire && (tail_reg == PTR_W'(gi));
        assign deq_here     = deq && (head_reg == PTR_W'(gi));
        assign res_here     = res_hit && (cand_sel == PTR_W'(gi));
        assign kill_hit[gi] = kill_en && valid_reg && (id_reg == commit_id_i);

        // The tail slot is never valid while a push is accepted, so a push
        // cannot collide with a dequeue, kill or completion of the same slot.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_reg  <= 1'b0;
                done_reg   <= 1'b0;
                killed_reg <= 1'b0;
                err_reg    <= 1'b0;
                we_reg     <= 1'b0;
                id_reg     <= '0;
                rd_reg     <= '0;
            end else if (push_here) begin
                valid_reg  <= 1'b1;
                done_reg   <= 1'b0;
                killed_reg <= 1'b0;
                err_reg    <= 1'b0;
                we_reg     <= push_we_i;
                id_reg     <= push_id_i;
                rd_reg     <= push_rd_i;
            end else if (deq_here) begin
                valid_reg  <= 1'b0;
                done_reg   <= 1'b0;
                killed_reg <= 1'b0;
                err_reg    <= 1'b0;
            end else begin
                if (kill_hit[gi]) begin
                    killed_reg <= 1'b1;
                end
                if (res_here) begin
                    done_reg <= 1'b1;
                    err_reg  <= result_err_i;
                end
            end
        end

        assign entry_valid[gi]  = valid_reg;
        assign entry_done[gi]   = done_reg;
        assign entry_killed[gi] = killed_reg;
        assign entry_err[gi]    = err_reg;
        assign entry_we[gi]     = we_reg;
        assign entry_id[gi]     = id_reg;
        assign entry_rd[gi]     = rd_reg;
    end

    // -----------------------------------------------------------------------
    // Result id check. The op is completed regardless; the flag only reports
    // that the memory side returned an unexpected id.
    // -----------------------------------------------------------------------
`ifdef FPU_SS_MEM_ID_CHECK_EN
    logic id_mismatch_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_mismatch_reg <= 1'b0;
        end else begin
            id_mismatch_reg <= res_hit && (entry_id[cand_sel] != result_id_i);
        end
    end

    assign id_mismatch_o = id_mismatch_reg;
`else
    logic unused_result_id;

    assign unused_result_id = ^result_id_i;
    assign id_mismatch_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_ss_mem_tracker.sv
`timescale 1ns / 1ps
// Self-checking bench for fpu_ss_mem_tracker (default parameters).
module tb_fpu_ss_mem_tracker;

    localparam int ID_W  = 4;
    localparam int DEPTH = 4;
    localparam int RD_W  = 5;
    localparam int NV    = 24;

`ifdef FPU_SS_MEM_ID_CHECK_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    logic            clk_i;
    logic            rst_ni;
    logic            push_valid_i;
    logic            push_ready_o;
    logic [ID_W-1:0] push_id_i;
    logic [RD_W-1:0] push_rd_i;
    logic            push_we_i;
    logic            commit_valid_i;
    logic [ID_W-1:0] commit_id_i;
    logic            commit_kill_i;
    logic            result_valid_i;
    logic [ID_W-1:0] result_id_i;
    logic            result_err_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [ID_W-1:0] out_id_o;
    logic [RD_W-1:0] out_rd_o;
    logic            out_we_o;
    logic            out_err_o;
    logic            empty_o;
    logic            full_o;
    logic [2:0]      count_o;
    logic            id_mismatch_o;

    fpu_ss_mem_tracker #(
        .ID_WIDTH (ID_W),
        .DEPTH    (DEPTH),
        .RD_WIDTH (RD_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .push_valid_i   (push_valid_i),
        .push_ready_o   (push_ready_o),
        .push_id_i      (push_id_i),
        .push_rd_i      (push_rd_i),
        .push_we_i      (push_we_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .result_valid_i (result_valid_i),
        .result_id_i    (result_id_i),
        .result_err_i   (result_err_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_id_o       (out_id_o),
        .out_rd_o       (out_rd_o),
        .out_we_o       (out_we_o),
        .out_err_o      (out_err_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .count_o        (count_o),
        .id_mismatch_o  (id_mismatch_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of ops expected to leave the output, in order
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            err;
    } sb_t;
    sb_t sb_q[$];

    // One table row: inputs for one cycle plus the state expected in it
    typedef struct {
        logic            pv;
        logic [ID_W-1:0] pid;
        logic [RD_W-1:0] prd;
        logic            pwe;
        logic            sbo;    // pushed op is expected at the output
        logic            sberr;  // err it will carry
        logic            cv;
        logic            ck;
        logic [ID_W-1:0] cid;
        logic            rv;
        logic [ID_W-1:0] rid;
        logic            rerr;
        logic            e_ov;
        logic [2:0]      e_cnt;
        logic            e_mm;   // mismatch pulse expected when the check is built
    } vec_t;
    vec_t vec [NV];

    function automatic vec_t mk(input int pv, input int pid, input int prd, input int pwe,
                                input int sbo, input int sberr, input int cv, input int ck,
                                input int cid, input int rv, input int rid, input int rerr,
                                input int e_ov, input int e_cnt, input int e_mm);
        vec_t v;
        v.pv = pv[0];   v.pid = ID_W'(pid); v.prd = RD_W'(prd); v.pwe = pwe[0];
        v.sbo = sbo[0]; v.sberr = sberr[0];
        v.cv = cv[0];   v.ck = ck[0];       v.cid = ID_W'(cid);
        v.rv = rv[0];   v.rid = ID_W'(rid); v.rerr = rerr[0];
        v.e_ov = e_ov[0]; v.e_cnt = 3'(e_cnt); v.e_mm = e_mm[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int ov, input int cnt);
        check({tag, ".out_valid"},  32'(out_valid_o),  32'(ov));
        check({tag, ".count"},      32'(count_o),      32'(cnt));
        check({tag, ".empty"},      32'(empty_o),      32'(cnt == 0));
        check({tag, ".full"},       32'(full_o),       32'(cnt == DEPTH));
        check({tag, ".push_ready"}, 32'(push_ready_o), 32'(cnt != DEPTH));
    endtask

    task automatic chk_mm(input string tag, input int mm);
        check({tag, ".id_mismatch"}, 32'(id_mismatch_o), 32'(mm[0] && MM_EN));
    endtask

    task automatic drive(input int pv, input int pid, input int prd, input int pwe,
                         input int cv, input int ck, input int cid,
                         input int rv, input int rid, input int rerr);
        push_valid_i   = pv[0];
        push_id_i      = ID_W'(pid);
        push_rd_i      = RD_W'(prd);
        push_we_i      = pwe[0];
        commit_valid_i = cv[0];
        commit_kill_i  = ck[0];
        commit_id_i    = ID_W'(cid);
        result_valid_i = rv[0];
        result_id_i    = ID_W'(rid);
        result_err_i   = rerr[0];
    endtask

    task automatic sb_push(input int id, input int rd, input int we, input int err);
        sb_t e;
        e.id  = ID_W'(id);
        e.rd  = RD_W'(rd);
        e.we  = we[0];
        e.err = err[0];
        sb_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Output monitor: every accepted output is matched against the scoreboard
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            check("out.sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_t e;
                e = sb_q.pop_front();
                $display("out  id=%0d rd=%0d we=%0d err=%0d (expected id=%0d rd=%0d we=%0d err=%0d)",
                         out_id_o, out_rd_o, out_we_o, out_err_o, e.id, e.rd, e.we, e.err);
                check("out.id",  32'(out_id_o),  32'(e.id));
                check("out.rd",  32'(out_rd_o),  32'(e.rd));
                check("out.we",  32'(out_we_o),  32'(e.we));
                check("out.err", 32'(out_err_o), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int np;
        int rid;

        // pv pid prd pwe sbo sberr | cv ck cid | rv rid rerr | ov cnt mm
        vec[0]  = mk(1, 1, 3, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
        vec[1]  = mk(1, 2, 4, 1, 1, 1,  0, 0, 0,  0, 0, 0,  0, 1, 0);
        vec[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 1, 0,  0, 2, 0);
        vec[3]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 2, 0);
        vec[4]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 2, 1,  0, 1, 0);
        vec[5]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1, 0);
        vec[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
        // kill of the older op; result lands on the younger one
        vec[7]  = mk(1, 5, 6, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
        vec[8]  = mk(1, 6, 7, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0);
        vec[9]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 5,  0, 0, 0,  0, 2, 0);
        vec[10] = mk(0, 0, 0, 0, 0, 0,  1, 0, 6,  1, 6, 0,  0, 2, 0);
        vec[11] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1, 0);
        vec[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
        // kill and result in the same cycle: result skips the killed op
        vec[13] = mk(1, 8, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
        vec[14] = mk(1, 9, 2, 0, 1, 1,  0, 0, 0,  0, 0, 0,  0, 1, 0);
        vec[15] = mk(0, 0, 0, 0, 0, 0,  1, 1, 8,  1, 8, 1,  0, 2, 0);
        vec[16] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 2, 1);
        vec[17] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1, 0);
        vec[18] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
        // result in the push cycle of the only op is ignored
        vec[19] = mk(1, 10, 9, 1, 1, 0, 0, 0, 0,  1, 10, 0, 0, 0, 0);
        vec[20] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0);
        vec[21] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 10, 0, 0, 1, 0);
        vec[22] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1, 0);
        vec[23] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);

        // ---------------- reset ----------------
        rst_ni      = 1'b0;
        out_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_state("reset", 0, 0);
        chk_mm("reset", 0);
        rst_ni = 1'b1;
        next_cyc();

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            drive(int'(vec[i].pv), int'(vec[i].pid), int'(vec[i].prd), int'(vec[i].pwe),
                  int'(vec[i].cv), int'(vec[i].ck), int'(vec[i].cid),
                  int'(vec[i].rv), int'(vec[i].rid), int'(vec[i].rerr));
            out_ready_i = 1'b1;
            if (vec[i].pv && vec[i].sbo)
                sb_push(int'(vec[i].pid), int'(vec[i].prd), int'(vec[i].pwe), int'(vec[i].sberr));
            @(negedge clk_i);
            $display("vec%0d count=%0d out_valid=%0d mismatch=%0d", i, count_o, out_valid_o, id_mismatch_o);
            chk_state($sformatf("vec%0d", i), int'(vec[i].e_ov), int'(vec[i].e_cnt));
            chk_mm($sformatf("vec%0d", i), int'(vec[i].e_mm));
            next_cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- fill, held push, pointer wrap ----------------
        out_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1, k, k, 1, 0, 0, 0, 0, 0, 0);
            sb_push(k, k, 1, k % 2);
            @(negedge clk_i);
            chk_state($sformatf("fill%0d", k), 0, k - 1);
            next_cyc();
        end
        drive(1, 5, 5, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk_state("full", 0, 4);
        next_cyc();
        drive(1, 5, 5, 1, 0, 0, 0, 1, 1, 1);
        @(negedge clk_i);
        chk_state("full_res", 0, 4);
        next_cyc();
        // pop while full: the waiting push must still be refused this cycle
        drive(1, 5, 5, 1, 0, 0, 0, 0, 0, 0);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        chk_state("full_pop", 1, 4);
        next_cyc();
        sb_push(5, 5, 1, 1);
        @(negedge clk_i);
        chk_state("after_pop", 0, 3);
        next_cyc();

        np  = 6;
        rid = 2;
        for (int k = 0; k < 8; k++) begin
            drive(1, np, np, 1, 0, 0, 0, 1, rid, rid % 2);
            if (k >= 2) sb_push(np, np, 1, np % 2);
            @(negedge clk_i);
            chk_state($sformatf("wrap%0d", k), (k >= 1) ? 1 : 0, (k < 2) ? 4 : 3);
            next_cyc();
            if (k >= 2) np++;
            rid++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 10, 0);
        @(negedge clk_i);
        chk_state("drain0", 1, 3);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 11, 1);
        @(negedge clk_i);
        chk_state("drain1", 1, 2);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk_state("drain2", 1, 1);
        next_cyc();
        @(negedge clk_i);
        chk_state("drain3", 0, 0);
        next_cyc();

        // ---------------- result id mismatch ----------------
        drive(1, 7, 7, 1, 0, 0, 0, 0, 0, 0);
        sb_push(7, 7, 1, 1);
        @(negedge clk_i);
        chk_state("mm0", 0, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
        @(negedge clk_i);
        chk_state("mm1", 0, 1);
        chk_mm("mm1", 0);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk_state("mm2", 1, 1);
        chk_mm("mm2", 1);
        next_cyc();
        @(negedge clk_i);
        chk_state("mm3", 0, 0);
        chk_mm("mm3", 0);
        next_cyc();

        // ---------------- reset mid-operation ----------------
        out_ready_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(1, k, k, 0, 0, 0, 0, 0, 0, 0);
            sb_push(k, k, 0, 0);
            next_cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk_state("pre_rst", 1, 3);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_state("rst_async", 0, 0);
        chk_mm("rst_async", 0);
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        next_cyc();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            @(negedge clk_i);
            chk_state($sformatf("post_rst%0d", k), 0, 0);
            chk_mm($sformatf("post_rst%0d", k), 0);
            next_cyc();
        end
        drive(1, 12, 12, 1, 0, 0, 0, 0, 0, 0);
        sb_push(12, 12, 1, 0);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        @(negedge clk_i);
        chk_state("post_rst_push", 0, 1);
        next_cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk_state("post_rst_out", 1, 1);
        next_cyc();
        @(negedge clk_i);
        chk_state("post_rst_done", 0, 0);
        next_cyc();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_ss_mem_tracker.md
FPU_SS_MEM_TRACKER -- requirements
Module: fpu_ss_mem_tracker

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, width of the offload instruction id.
REQ-002 SHALL have parameter DEPTH, default 4, number of outstanding memory ops; power of two, >= 2.
REQ-003 SHALL have parameter RD_WIDTH, default 5, width of the destination register address.
REQ-004 SHALL have ports: clk_i  in  1  clock; all state on rising edge.
REQ-005 SHALL have ports: rst_ni  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: push_valid_i  in  1 / push_ready_o  out  1 / push_id_i  in  ID_WIDTH / push_rd_i  in  RD_WIDTH / push_we_i  in  1; issue of a load/store, we=1 for an FP-register load.
REQ-007 SHALL have ports: commit_valid_i  in  1 / commit_id_i  in  ID_WIDTH / commit_kill_i  in  1; commit interface.
REQ-008 SHALL have ports: result_valid_i  in  1 / result_id_i  in  ID_WIDTH / result_err_i  in  1; memory result interface, no backpressure.
REQ-009 SHALL have ports: out_valid_o  out  1 / out_ready_i  in  1 / out_id_o  out  ID_WIDTH / out_rd_o  out  RD_WIDTH / out_we_o  out  1 / out_err_o  out  1; completed-op output.
REQ-010 SHALL have ports: empty_o  out  1 / full_o  out  1 / count_o  out  $clog2(DEPTH+1) / id_mismatch_o  out  1.

Function
REQ-011 SHALL be an in-order circular buffer of DEPTH entries {id, rd, we, done, killed, err}, with head and tail pointers of $clog2(DEPTH) bits that wrap DEPTH-1 -> 0.
REQ-012 SHALL set push_ready_o = !full_o; push accepted when push_valid_i && push_ready_o, writing the tail entry with done=0, killed=0, err=0.
REQ-013 SHALL not bypass: a push while full is not accepted, even when a pop occurs in the same cycle.
REQ-014 SHALL, on commit_valid_i && commit_kill_i, set killed=1 in every valid entry whose id equals commit_id_i; commit without kill has no effect.
REQ-015 SHALL, on result_valid_i, mark the oldest valid entry with done=0 and killed=0 as done=1, with err=result_err_i.
REQ-016 SHALL ignore result_valid_i when no such entry exists; no state change.
REQ-017 SHALL pulse id_mismatch_o high for one cycle, registered, in the cycle after a result whose result_id_i differs from the selected entry's id; the entry is still marked done.
REQ-018 SHALL assert out_valid_o when the head entry is valid, done=1 and killed=0; out_* fields are driven from the head entry; pop on out_valid_o && out_ready_i.
REQ-019 SHALL drop a killed head entry automatically in one cycle without asserting out_valid_o, whether or not it is done.
REQ-020 SHALL reach out_valid_o one cycle after the result edge for the head entry; a result is never forwarded combinationally.
REQ-021 SHALL hold out_* stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL update count_o = count + push - pop(or drop) each cycle; empty_o = (count==0); full_o = (count==DEPTH).
REQ-023 SHALL apply a kill and a result in the same cycle as follows: the kill updates first, so the result selects among entries not killed after that kill.
REQ-024 SHALL apply a same-cycle push to the new entry only from the next cycle; it is not visible to the kill or result in its push cycle.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously clear the pointers, count, all valid/done/killed/err bits and id_mismatch_o.
REQ-026 SHALL hold these reset output values: push_ready_o=1, out_valid_o=0, empty_o=1, full_o=0, count_o=0, id_mismatch_o=0.
REQ-027 SHALL discard all in-flight entries on a reset asserted mid-operation; no output follows reset release until new pushes arrive.

Configuration
REQ-028 SHALL implement the id check with macro FPU_SS_MEM_ID_CHECK_EN. Defined: REQ-017 behaviour. Undefined: id_mismatch_o tied 0, no comparator or register.

Verification
REQ-029 SHALL cover: push ids 1,2 (rd 3,4); result id1 at cycle N -> out_valid at N+1 with id=1, rd=3; then result id2 -> id=2, rd=4.
REQ-030 SHALL cover: push 4 entries (DEPTH=4) -> full_o=1, push_ready_o=0; a 5th push is held until a pop; count_o wraps correctly through 8 push/pop cycles.
REQ-031 SHALL cover: push ids 5,6; kill id5; result id6 -> id5 dropped silently, out_valid with id=6, count_o=0 after pop.
REQ-032 SHALL cover: push id7, then result_id=3 -> id_mismatch_o pulses 1 cycle, id7 out with err as sent; macro undefined -> id_mismatch_o stays 0.
REQ-033 SHALL cover: 3 entries outstanding, out_ready_i=0 with head done; assert rst_ni low -> all outputs take reset values immediately; no stale output after release.
